// File: rtl/multi_edge_detector.sv
// multi_edge_detector
// Per-channel synchroniser, debounce filter and edge reporter. Each channel
// reports mode-selected edges of its debounced level as a one-cycle pulse,
// a sticky pending flag and a saturating event count. Channels share no state.
module multi_edge_detector #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       async_in,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       clear,
   output logic [CHANNELS-1:0]       pulse,
   output logic [CHANNELS-1:0]       pending,
   output logic [CHANNELS-1:0]       level,
   output logic [CHANNELS*CNT_W-1:0] count
);

   // Debounce counter is wide enough to reach DEBOUNCE-1; at least one bit.
   localparam int              DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic [SYNC_STAGES-1:0] sync_d;
         logic [DB_W-1:0]        db_cnt_q;
         logic [DB_W-1:0]        db_cnt_d;
         logic                   level_q;
         logic                   level_d;
         logic                   pulse_q;
         logic                   pulse_d;
         logic                   pending_q;
         logic                   pending_d;
         logic [CNT_W-1:0]       count_q;
         logic [CNT_W-1:0]       count_d;
         logic                   s;
         logic                   update;
         logic                   event_hit;

         // The last synchroniser stage is the only view of the raw input.
         assign s = sync_q[SYNC_STAGES-1];

         // Shift the raw input one stage further down the synchroniser chain.
         always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], async_in[gi]};
         end

         // Count consecutive cycles that s disagrees with level; adopt s after DEBOUNCE of them.
         always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            update   = 1'b0;
            if (s != level_q) begin
               if (db_cnt_q == DB_LAST) begin
                  level_d = s;
                  update  = 1'b1;
               end else begin
                  db_cnt_d = db_cnt_q + 1'b1;
               end
            end
         end

         // Qualify the update against mode, then fold it into pending/count; an event beats clear.
         always_comb begin
            // s carries the new level during an update: 1 means rise, 0 means fall.
            event_hit = update && (s ? mode[2*gi] : mode[2*gi+1]);
            pulse_d   = event_hit;
            pending_d = pending_q;
            count_d   = count_q;
            if (event_hit) begin
               pending_d = 1'b1;
               if (clear[gi]) begin
                  count_d = CNT_W'(1);
               end else if (count_q != {CNT_W{1'b1}}) begin
                  count_d = count_q + 1'b1;
               end
            end else if (clear[gi]) begin
               pending_d = 1'b0;
               count_d   = '0;
            end
         end

         // Channel state register; every flop clears on reset.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync_q    <= '0;
               db_cnt_q  <= '0;
               level_q   <= 1'b0;
               pulse_q   <= 1'b0;
               pending_q <= 1'b0;
               count_q   <= '0;
            end else begin
               sync_q    <= sync_d;
               db_cnt_q  <= db_cnt_d;
               level_q   <= level_d;
               pulse_q   <= pulse_d;
               pending_q <= pending_d;
               count_q   <= count_d;
            end
         end

         assign pulse[gi]                  = pulse_q;
         assign pending[gi]                = pending_q;
         assign level[gi]                  = level_q;
         assign count[CNT_W*gi +: CNT_W]   = count_q;
      end
   endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: a 4-channel 8-bit-count instance plus a
// 1-channel 2-bit-count instance for saturation. A reference model predicts
// each reported event; a monitor pops and compares whenever a pulse appears.
module tb_multi_edge_detector;

   localparam int CH     = 4;
   localparam int S      = 2;
   localparam int D      = 4;
   localparam int CW     = 8;
   localparam int SAT_CW = 2;
   localparam int NCH    = CH + 1;   // model channel 4 is the saturation instance

   logic              clk      = 1'b0;
   logic              reset_n  = 1'b0;
   logic [CH-1:0]     async_in = '0;
   logic [2*CH-1:0]   mode     = '0;
   logic [CH-1:0]     clear    = '0;
   logic [CH-1:0]     pulse;
   logic [CH-1:0]     pending;
   logic [CH-1:0]     level;
   logic [CH*CW-1:0]  count;

   logic              sat_async = 1'b0;
   logic [1:0]        sat_mode  = 2'b00;
   logic              sat_clear = 1'b0;
   logic              sat_pulse;
   logic              sat_pending;
   logic              sat_level;
   logic [SAT_CW-1:0] sat_count;

   logic [NCH-1:0]    all_async;
   logic [NCH-1:0]    all_clear;
   logic [2*NCH-1:0]  all_mode;
   logic [NCH-1:0]    all_pulse;
   logic [NCH-1:0]    all_pending;
   logic [NCH-1:0]    all_level;

   assign all_async   = {sat_async, async_in};
   assign all_clear   = {sat_clear, clear};
   assign all_mode    = {sat_mode, mode};
   assign all_pulse   = {sat_pulse, pulse};
   assign all_pending = {sat_pending, pending};
   assign all_level   = {sat_level, level};

   multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(CW)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (async_in),
      .mode     (mode),
      .clear    (clear),
      .pulse    (pulse),
      .pending  (pending),
      .level    (level),
      .count    (count)
   );

   multi_edge_detector #(.CHANNELS(1), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(SAT_CW)) u_sat (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (sat_async),
      .mode     (sat_mode),
      .clear    (sat_clear),
      .pulse    (sat_pulse),
      .pending  (sat_pending),
      .level    (sat_level),
      .count    (sat_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(string name, int ch, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", name, ch, act, exp, $time);
      end
   endtask

   function automatic int cnt_of(int ch);
      if (ch < CH) return int'(count[ch*CW +: CW]);
      return int'(sat_count);
   endfunction

   // ---------------- reference model ----------------
   // Raw samples taken at each edge since reset; s at an edge is the sample
   // taken S edges earlier. run counts consecutive edges where that sample
   // disagreed with the filtered level.
   logic [NCH-1:0] hist[$];
   int             run  [NCH];
   bit             lvl  [NCH];
   bit             pend [NCH];
   int             cnt  [NCH];
   int             exp_q[NCH][$];

   task automatic model_clear();
      hist.delete();
      for (int ch = 0; ch < NCH; ch++) begin
         run[ch]  = 0;
         lvl[ch]  = 1'b0;
         pend[ch] = 1'b0;
         cnt[ch]  = 0;
         exp_q[ch].delete();
      end
   endtask

   task automatic model_step();
      logic [NCH-1:0] sp;
      sp = '0;
      if (hist.size() >= S) sp = hist[hist.size() - S];
      hist.push_back(all_async);
      if (hist.size() > S) void'(hist.pop_front());
      for (int ch = 0; ch < NCH; ch++) begin
         bit hit;
         int mx;
         hit = 1'b0;
         mx  = (ch < CH) ? (1 << CW) - 1 : (1 << SAT_CW) - 1;
         if (sp[ch] != lvl[ch]) begin
            run[ch]++;
            if (run[ch] == D) begin
               lvl[ch] = sp[ch];
               run[ch] = 0;
               hit = sp[ch] ? all_mode[2*ch] : all_mode[2*ch+1];
            end
         end else begin
            run[ch] = 0;
         end
         if (hit) begin
            pend[ch] = 1'b1;
            if (all_clear[ch]) cnt[ch] = 1;
            else if (cnt[ch] < mx) cnt[ch] = cnt[ch] + 1;
            exp_q[ch].push_back(cnt[ch]);
         end else if (all_clear[ch]) begin
            pend[ch] = 1'b0;
            cnt[ch]  = 0;
         end
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_clear();
         else model_step();
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("reset_pulse",   0, int'(all_pulse),   0);
            chk("reset_pending", 0, int'(all_pending), 0);
            chk("reset_level",   0, int'(all_level),   0);
            chk("reset_count",   0, int'(count),       0);
            chk("reset_satcnt",  4, int'(sat_count),   0);
         end else begin
            for (int ch = 0; ch < NCH; ch++) begin
               chk("pulse", ch, int'(all_pulse[ch]), int'(exp_q[ch].size() != 0));
               if (exp_q[ch].size() != 0) begin
                  int e;
                  e = exp_q[ch].pop_front();
                  if (all_pulse[ch]) begin
                     $display("pulse ch%0d count=%0d level=%0d t=%0t", ch, cnt_of(ch), all_level[ch], $time);
                     chk("count_at_pulse", ch, cnt_of(ch), e);
                  end
               end
               chk("level",   ch, int'(all_level[ch]),   int'(lvl[ch]));
               chk("pending", ch, int'(all_pending[ch]), int'(pend[ch]));
               chk("count",   ch, cnt_of(ch),            cnt[ch]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edges are numbered from 1 after the call; reports the first pulse edge and pulse count.
   task automatic wait_pulse(int ch, int lim, output int lat, output int np);
      lat = -1;
      np  = 0;
      for (int e = 1; e <= lim; e++) begin
         @(posedge clk);
         #1;
         if (all_pulse[ch]) begin
            np++;
            if (lat < 0) lat = e;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int np;
      int sat_exp[6];
      sat_exp = '{1, 2, 3, 3, 3, 3};

      // Reset state
      step(3);
      chk("reset_state", 0, int'({pulse, pending, level}), 0);
      reset_n = 1'b1;
      step(2);

      // Single-channel rise
      $display("test: rise ch0");
      mode = 8'b00_00_00_01;
      async_in[0] = 1'b1;
      wait_pulse(0, 20, lat, np);
      chk("rise_latency", 0, lat, 6);
      chk("rise_npulse",  0, np, 1);
      chk("rise_level",   0, int'(level[0]), 1);
      chk("rise_pending", 0, int'(pending[0]), 1);
      chk("rise_count",   0, int'(count[7:0]), 1);
      chk("rise_others",  1, int'({pulse[3:1], pending[3:1], level[3:1]}), 0);
      chk("rise_oth_cnt", 1, int'(count[31:8]), 0);

      // Glitch rejection, then a just-long-enough pulse
      $display("test: glitch ch0");
      mode[1:0] = 2'b11;
      async_in[0] = 1'b0;
      step(12);
      chk("fall_count", 0, int'(count[7:0]), 2);
      async_in[0] = 1'b1;
      step(3);
      async_in[0] = 1'b0;
      step(12);
      chk("glitch_level", 0, int'(level[0]), 0);
      chk("glitch_count", 0, int'(count[7:0]), 2);
      async_in[0] = 1'b1;
      step(4);
      async_in[0] = 1'b0;
      wait_pulse(0, 8, lat, np);
      chk("pulse4_latency", 0, lat, 2);
      chk("pulse4_npulse",  0, np, 2);
      chk("pulse4_count",   0, int'(count[7:0]), 4);

      // Mode coverage
      $display("test: mode coverage");
      clear = 4'b1111;
      step(1);
      clear = 4'b0000;
      mode = 8'b00_00_10_11;
      async_in[2:0] = 3'b111;
      step(10);
      chk("mode_ch2_level_hi", 2, int'(level[2]), 1);
      async_in[2:0] = 3'b000;
      step(10);
      chk("mode_ch0_count", 0, int'(count[7:0]), 2);
      chk("mode_ch1_count", 1, int'(count[15:8]), 1);
      chk("mode_ch2_count", 2, int'(count[23:16]), 0);
      chk("mode_ch2_level_lo", 2, int'(level[2]), 0);

      // Clear colliding with an event
      $display("test: clear collision");
      mode = 8'b00_00_00_11;
      clear = 4'b0001;
      step(1);
      clear = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         async_in[0] = ~async_in[0];
         step(10);
      end
      chk("pre_clr_count",   0, int'(count[7:0]), 5);
      chk("pre_clr_pending", 0, int'(pending[0]), 1);
      async_in[0] = ~async_in[0];
      step(5);
      clear[0] = 1'b1;
      step(1);
      clear[0] = 1'b0;
      chk("collide_pending", 0, int'(pending[0]), 1);
      chk("collide_count",   0, int'(count[7:0]), 1);
      step(10);
      clear[0] = 1'b1;
      step(1);
      clear[0] = 1'b0;
      chk("lone_clr_pending", 0, int'(pending[0]), 0);
      chk("lone_clr_count",   0, int'(count[7:0]), 0);

      // Saturation on the 2-bit instance
      $display("test: saturation");
      sat_mode = 2'b11;
      for (int i = 0; i < 6; i++) begin
         sat_async = ~sat_async;
         wait_pulse(4, 10, lat, np);
         chk("sat_latency", 4, lat, 6);
         chk("sat_npulse",  4, np, 1);
         chk("sat_count",   4, int'(sat_count), sat_exp[i]);
      end

      // Reset in the middle of a debounce
      $display("test: reset mid-debounce");
      mode = 8'b00_00_00_01;
      async_in = 4'b1000;
      step(10);
      chk("pre_rst_level3", 3, int'(level[3]), 1);
      async_in[0] = 1'b1;
      step(4);
      reset_n = 1'b0;
      #1;
      chk("midrst_flags", 0, int'({pulse, pending, level, sat_pulse, sat_pending, sat_level}), 0);
      chk("midrst_count", 0, int'(count), 0);
      step(3);
      reset_n = 1'b1;
      wait_pulse(0, 12, lat, np);
      chk("post_rst_latency", 0, lat, 6);
      chk("post_rst_npulse",  0, np, 1);

      // Randomised traffic checked by the model
      $display("test: random");
      for (int c = 0; c < 800; c++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if ($urandom_range(0, 7) == 0) async_in[ch] = ~async_in[ch];
            clear[ch] = ($urandom_range(0, 15) == 0);
         end
         if ($urandom_range(0, 7) == 0) sat_async = ~sat_async;
         sat_clear = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
         if ($urandom_range(0, 39) == 0) sat_mode = 2'($urandom);
         step(1);
      end
      clear = '0;
      sat_clear = 1'b0;
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel successor to the single-channel edge detector. Each channel synchronises an asynchronous input into the `clk` domain, debounces it, and reports rising, falling or both edges according to a per-channel mode. A report is a one-cycle pulse, a sticky pending flag and a saturating event count. It sits between board-level inputs (keys, switches, external strobes) and the control FSMs, which can either react to `pulse` or poll and clear `pending` and `count`.

## Interface
- `CHANNELS`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flop depth (≥2).
- `DEBOUNCE`, default 4: cycles the synchronised input must differ from the filtered level before the level updates (≥1; 1 = no filtering).
- `CNT_W`, default 8: width of each per-channel event counter (≥1).

- `clk`, input, 1: sole clock; all state is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `async_in`, input, CHANNELS: raw asynchronous inputs, one bit per channel.
- `mode`, input, 2*CHANNELS: channel i uses bits [2i+1:2i]. 00 off, 01 rise, 10 fall, 11 both. Synchronous to `clk`.
- `clear`, input, CHANNELS: synchronous per-channel clear of `pending` and `count`.
- `pulse`, output, CHANNELS: one-cycle event strobe.
- `pending`, output, CHANNELS: sticky event flag.
- `level`, output, CHANNELS: debounced, synchronised input level.
- `count`, output, CHANNELS*CNT_W: channel i event count at bits [CNT_W*i +: CNT_W]; saturating.

## Operation
Each channel is fully independent; there is no shared state.
- **Synchroniser:** a chain of SYNC_STAGES flops, all reset to 0. `s` is the last stage output. Nothing else samples `async_in`.
- **Debounce:**
  - A counter of width clog2(DEBOUNCE) (min 1) and `level`, both reset to 0.
  - If `s == level`: counter <= 0.
  - Else if counter == DEBOUNCE-1: `level` <= `s`, counter <= 0 (an "update").
  - Else: counter <= counter+1.
  - Any return of `s` to `level` before the update restarts the count from 0.
- **Edge qualification:**
  - A rise is an update where `level` goes 0→1; a fall is an update where it goes 1→0.
  - `pulse` is registered. It is 1 in exactly the cycle in which `level` first shows the new value, and only if the edge type is enabled by `mode` at the update edge. It is otherwise 0.
  - Mode 00 suppresses all reporting, but `level` still tracks the input.
  - Changing `mode` never creates an event by itself.
- **pending:**
  - Set by any pulse-qualifying event and cleared by `clear`.
  - If an event and `clear` occur on the same edge, set wins: `pending` = 1.
- **count:**
  - Increments by 1 per qualifying event and saturates at 2^CNT_W-1 (no wrap).
  - `clear` loads 0.
  - If an event and `clear` occur on the same edge, count = 1.
- **Reset:**
  - Every flop goes to 0, so `pulse`, `pending`, `level` and `count` are all 0 while `reset_n` is low.
  - An input already high at reset release is reported as a rise, S+D cycles after release, if the mode enables rises.

## Timing
- Let S = SYNC_STAGES and D = DEBOUNCE. Take `async_in` changing, and staying stable, between edges k-1 and k.
- `s` shows the new value after edge k+S-1. `level` and `pulse` update after edge k+S+D-1; `pulse` drops after the next edge.
- Worst-case latency from the input change to `pulse` is S+D cycles, plus up to one cycle of sampling uncertainty.
- `pending` and `count` update on the same edge as `pulse`; `clear` acts on the next edge.
- A glitch on `s` lasting fewer than D cycles produces no update, no pulse and no count.
- Minimum spacing between two reported edges on one channel is D cycles.
- Asserting `reset_n` low mid-debounce aborts the debounce immediately. After release, detection needs a full S+D again.
- Channels never interact: simultaneous events on all channels each pulse in the same cycle.

## Test plan
Use S=2, D=4, CNT_W=8 unless stated. All cycle numbers count edges after the input change.
- **Rise, single channel:** ch0 mode=01; `async_in[0]` 0→1, held. `pulse[0]`=1 for exactly one cycle at edge 6; `level[0]`=1; `pending[0]`=1; `count[0]`=1. Other channels stay all-zero.
- **Glitch rejection:** ch0 `async_in` high for 3 cycles, then low. No pulse; `level[0]` stays 0; counts are unchanged. Repeat with a 4-cycle pulse: the rise is reported.
- **Mode coverage:** ch0 mode=11, ch1 mode=10, ch2 mode=00; each input does rise, waits 10 cycles, then falls.
  - ch0: two pulses, `count`=2.
  - ch1: one pulse, on the fall only.
  - ch2: none, but its `level` still tracks.
- **Clear collision:** ch0 `pending`=1, `count`=5; assert `clear[0]` on the same edge as a new event. Result: `pending`=1, `count`=1. A lone `clear` gives 0/0.
- **Saturation:** CNT_W=2, mode=11, six toggles spaced 10 cycles apart. `count` reads 1, 2, 3, 3, 3, 3, and pulses continue.
- **Reset mid-operation:**
  - Drop `reset_n` 2 cycles into a debounce: all outputs 0 immediately.
  - Release with the input held high and mode=01: one rise pulse at edge 6 after release, none earlier.
